// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: control-word encodings and FSM states.
// Control word is {alu_sel_shift, alu_ctrl}, matching the ALU decoder output.
package alu_pkg;

   localparam logic [4:0] ALU_AND = 5'b0_0000;
   localparam logic [4:0] ALU_OR  = 5'b0_0001;
   localparam logic [4:0] ALU_ADD = 5'b0_0010;
   localparam logic [4:0] ALU_XOR = 5'b0_0011;
   localparam logic [4:0] ALU_NOR = 5'b0_0100;
   localparam logic [4:0] ALU_SUB = 5'b0_0110;
   localparam logic [4:0] ALU_SLT = 5'b0_0111;
   localparam logic [4:0] ALU_SLL = 5'b1_1000;
   localparam logic [4:0] ALU_SRL = 5'b1_1001;
   localparam logic [4:0] ALU_SRA = 5'b1_1010;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_HOLD  = 2'd2
   } alu_state_e;

endpackage

// File: rtl/alu_serial_shifter.sv
// One-bit-per-cycle shifter with a down-counter. Loaded on start; shifts while the
// counter is non-zero. done is high in the cycle whose shift is the last one, and
// shift_out is the value after that cycle's shift.
module alu_serial_shifter #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               dir_right,
   input  logic               arith,
   input  logic [WIDTH-1:0]   din,
   input  logic [SHAMT_W-1:0] amount,
   output logic [WIDTH-1:0]   shift_out,
   output logic               done
);

   logic [WIDTH-1:0]   data_q, data_d;
   logic [SHAMT_W-1:0] cnt_q, cnt_d;
   logic               right_q, right_d;
   logic               arith_q, arith_d;

   // Single-bit shift of the held value; vacated MSB copies the sign only for sra.
   always_comb begin
      if (right_q) begin
         shift_out = {arith_q & data_q[WIDTH-1], data_q[WIDTH-1:1]};
      end else begin
         shift_out = {data_q[WIDTH-2:0], 1'b0};
      end
      done = (cnt_q == SHAMT_W'(1));
   end

   // Load on start, otherwise shift and count down until the counter empties.
   always_comb begin
      data_d  = data_q;
      cnt_d   = cnt_q;
      right_d = right_q;
      arith_d = arith_q;
      if (start) begin
         data_d  = din;
         cnt_d   = amount;
         right_d = dir_right;
         arith_d = arith;
      end else if (cnt_q != '0) begin
         data_d = shift_out;
         cnt_d  = cnt_q - SHAMT_W'(1);
      end
   end

   // Shifter state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= '0;
         cnt_q   <= '0;
         right_q <= 1'b0;
         arith_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         right_q <= right_d;
         arith_q <= arith_d;
      end
   end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshake and registered result/flags.
// Build option: define ALU_BARREL_SHIFT_EN for single-cycle barrel shifts; otherwise
// shifts run serially one bit per cycle and busy stalls the front of the pipe.
//
// state   | meaning
// S_IDLE  | nothing held, ready for an operation
// S_SHIFT | serial shift running, busy=1, out_valid=0
// S_HOLD  | result and flags presented, out_valid=1
module alu_exec_unit
   import alu_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               alu_sel_shift,
   input  logic [3:0]         alu_ctrl,
   input  logic [WIDTH-1:0]   src_a,
   input  logic [WIDTH-1:0]   src_b,
   input  logic [SHAMT_W-1:0] shamt,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   result,
   output logic               zero,
   output logic               overflow,
   output logic               illegal,
   output logic               busy
);

   alu_state_e       state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d;
   logic             ovf_q, ovf_d;
   logic             ill_q, ill_d;

   logic [4:0]       ctrl_w;
   logic [WIDTH-1:0] op_res;
   logic [WIDTH-1:0] add_res;
   logic [WIDTH-1:0] sub_res;
   logic             op_ovf;
   logic             op_ill;
   logic             op_shift;
   logic             shift_right;
   logic             shift_arith;
   logic             accept;
   logic             go_serial;
   logic             shift_start;
   logic [WIDTH-1:0] shift_out;
   logic             shift_done;

   // Handshake and status decode from the current state.
   always_comb begin
      in_ready  = (state_q == S_IDLE) || ((state_q == S_HOLD) && out_ready);
      accept    = in_valid && in_ready;
      out_valid = (state_q == S_HOLD);
      busy      = (state_q == S_SHIFT);
   end

   // Single-cycle datapath for every control word presented on the inputs.
   always_comb begin
      ctrl_w      = {alu_sel_shift, alu_ctrl};
      add_res     = src_a + src_b;
      sub_res     = src_a - src_b;
      op_res      = '0;
      op_ovf      = 1'b0;
      op_ill      = 1'b0;
      op_shift    = 1'b0;
      shift_right = 1'b0;
      shift_arith = 1'b0;
      case (ctrl_w)
         ALU_AND: op_res = src_a & src_b;
         ALU_OR:  op_res = src_a | src_b;
         ALU_XOR: op_res = src_a ^ src_b;
         ALU_NOR: op_res = ~(src_a | src_b);
         ALU_ADD: begin
            op_res = add_res;
            op_ovf = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (add_res[WIDTH-1] != src_a[WIDTH-1]);
         end
         ALU_SUB: begin
            op_res = sub_res;
            op_ovf = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (sub_res[WIDTH-1] != src_a[WIDTH-1]);
         end
         ALU_SLT: op_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
         ALU_SLL: begin
            op_shift = 1'b1;
`ifdef ALU_BARREL_SHIFT_EN
            op_res = src_b << shamt;
`else
            op_res = src_b;
`endif
         end
         ALU_SRL: begin
            op_shift    = 1'b1;
            shift_right = 1'b1;
`ifdef ALU_BARREL_SHIFT_EN
            op_res = src_b >> shamt;
`else
            op_res = src_b;
`endif
         end
         ALU_SRA: begin
            op_shift    = 1'b1;
            shift_right = 1'b1;
            shift_arith = 1'b1;
`ifdef ALU_BARREL_SHIFT_EN
            op_res = $unsigned($signed(src_b) >>> shamt);
`else
            op_res = src_b;
`endif
         end
         default: op_ill = 1'b1;
      endcase
   end

`ifdef ALU_BARREL_SHIFT_EN
   assign go_serial  = 1'b0;
   assign shift_out  = '0;
   assign shift_done = 1'b0;
`else
   // A zero shift amount is resolved in the single-cycle path; only real shifts go serial.
   assign go_serial = op_shift && (shamt != '0);

   alu_serial_shifter #(
      .WIDTH   (WIDTH),
      .SHAMT_W (SHAMT_W)
   ) u_shifter (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (shift_start),
      .dir_right (shift_right),
      .arith     (shift_arith),
      .din       (src_b),
      .amount    (shamt),
      .shift_out (shift_out),
      .done      (shift_done)
   );
`endif

   // Next-state and result capture; HOLD with out_ready and a new accept chains with no bubble.
   always_comb begin
      state_d     = state_q;
      result_d    = result_q;
      zero_d      = zero_q;
      ovf_d       = ovf_q;
      ill_d       = ill_q;
      shift_start = 1'b0;
      case (state_q)
         S_SHIFT: begin
            if (shift_done) begin
               state_d  = S_HOLD;
               result_d = shift_out;
               zero_d   = (shift_out == '0);
               ovf_d    = 1'b0;
               ill_d    = 1'b0;
            end
         end
         default: begin
            if (accept) begin
               if (go_serial) begin
                  shift_start = 1'b1;
                  state_d     = S_SHIFT;
               end else begin
                  state_d  = S_HOLD;
                  result_d = op_res;
                  zero_d   = (op_res == '0);
                  ovf_d    = op_ovf;
                  ill_d    = op_ill;
               end
            end else if ((state_q == S_HOLD) && out_ready) begin
               state_d = S_IDLE;
            end
         end
      endcase
   end

   // State and registered output flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         result_q <= '0;
         zero_q   <= 1'b0;
         ovf_q    <= 1'b0;
         ill_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         ovf_q    <= ovf_d;
         ill_q    <= ill_d;
      end
   end

   assign result   = result_q;
   assign zero     = zero_q;
   assign overflow = ovf_q;
   assign illegal  = ill_q;

endmodule
